// File: rtl/vertex_matrix_builder.sv
// Collects NV vertices into a column-major 4xNV fixed-point matrix with a homogeneous W term
// and hands the whole matrix to the transform stage over a valid/ready handshake.
module vertex_matrix_builder #(
  parameter int DW   = 21,
  parameter int FRAC = 10,
  parameter int NV   = 4,
  parameter int CW   = $clog2(NV + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_x,
  input  logic signed [DW-1:0]   in_y,
  input  logic signed [DW-1:0]   in_z,
  input  logic signed [DW-1:0]   in_w,
  input  logic                   in_wsel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NV*DW-1:0]     out_mtrx,
  output logic [CW-1:0]          out_cols
);

  typedef enum logic {S_FILL, S_FULL} state_t;

  localparam logic signed [DW-1:0] W_ONE = DW'(64'sd1 <<< FRAC);

  function automatic logic [4*DW-1:0] pack_col(
    input logic signed [DW-1:0] x,
    input logic signed [DW-1:0] y,
    input logic signed [DW-1:0] z,
    input logic signed [DW-1:0] w
  );
    return {x, y, z, w};
  endfunction

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CW-1:0]       r_ptr;
  logic [CW-1:0]       r_cols;
  logic [4*DW-1:0]     r_col [NV];

  logic                w_acc;
  logic                w_close;
  logic signed [DW-1:0] w_wval;
  logic [4*DW-1:0]     w_col_in;

  assign w_acc    = in_valid && r_in_ready;
  assign w_close  = (r_ptr == CW'(NV - 1)) || in_last;
  assign w_wval   = in_wsel ? in_w : W_ONE;
  assign w_col_in = pack_col(in_x, in_y, in_z, w_wval);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
      r_cols      <= '0;
      for (int j = 0; j < NV; j++) r_col[j] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_acc) begin
            // Columns past the closing vertex are cleared so padding (W=0) is unambiguous
            for (int j = 0; j < NV; j++) begin
              if (CW'(j) == r_ptr)
                r_col[j] <= w_col_in;
              else if (w_close && (CW'(j) > r_ptr))
                r_col[j] <= '0;
            end
            if (w_close) begin
              r_state     <= S_FULL;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_cols      <= r_ptr + CW'(1);
              r_ptr       <= '0;
            end else begin
              r_ptr <= r_ptr + CW'(1);
            end
          end
        end
        S_FULL: begin
          if (out_ready) begin
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_FILL;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Column 0 occupies the most significant 4*DW bits
  for (genvar g = 0; g < NV; g++) begin : g_pack
    assign out_mtrx[4*DW*(NV-g)-1 -: 4*DW] = r_col[g];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_cols  = r_cols;

endmodule

// File: tb/tb_vertex_matrix_builder.sv
// Directed bench for vertex_matrix_builder: NV=4 main instance plus NV=1 and NV=8 builds.
module tb_vertex_matrix_builder;

  localparam int DW  = 21;
  localparam int ONE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                  in_valid, in_ready, in_wsel, in_last, out_valid, out_ready;
  logic signed [DW-1:0]  in_x, in_y, in_z, in_w;
  logic [16*DW-1:0]      out_mtrx;
  logic [2:0]            out_cols;

  logic                  a_valid, a_ready, a_ovalid, a_oready;
  logic signed [DW-1:0]  a_x, a_y, a_z;
  logic [4*DW-1:0]       a_mtrx;
  logic [0:0]            a_cols;

  logic                  b_valid, b_ready, b_ovalid, b_oready;
  logic signed [DW-1:0]  b_x, b_y, b_z;
  logic [32*DW-1:0]      b_mtrx;
  logic [3:0]            b_cols;

  int checks = 0;
  int errors = 0;

  vertex_matrix_builder #(.DW(21), .FRAC(10), .NV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w),
    .in_wsel(in_wsel), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_mtrx(out_mtrx), .out_cols(out_cols)
  );

  vertex_matrix_builder #(.DW(21), .FRAC(10), .NV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_x(a_x), .in_y(a_y), .in_z(a_z), .in_w(21'sd0),
    .in_wsel(1'b0), .in_last(1'b0), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_mtrx(a_mtrx), .out_cols(a_cols)
  );

  vertex_matrix_builder #(.DW(21), .FRAC(10), .NV(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_x(b_x), .in_y(b_y), .in_z(b_z), .in_w(21'sd0),
    .in_wsel(1'b0), .in_last(1'b0), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_mtrx(b_mtrx), .out_cols(b_cols)
  );

  function automatic logic [4*DW-1:0] col(input int x, input int y, input int z, input int w);
    return {x[DW-1:0], y[DW-1:0], z[DW-1:0], w[DW-1:0]};
  endfunction

  task automatic send(input int x, input int y, input int z, input int w,
                      input logic wsel, input logic last);
    int n;
    in_x = x[DW-1:0]; in_y = y[DW-1:0]; in_z = z[DW-1:0]; in_w = w[DW-1:0];
    in_wsel = wsel; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_wsel = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if (out_cols !== 3'd0) begin errors++; $display("FAIL rst_out_cols got %0d want 0", out_cols); end
    checks++; if (out_mtrx !== '0) begin errors++; $display("FAIL rst_out_mtrx got %h want 0", out_mtrx); end
  endtask

  task automatic test_full_batch();
    logic [16*DW-1:0] exp;
    exp = {col(1,2,3,ONE), col(4,5,6,ONE), col(7,8,9,ONE), col(10,11,12,ONE)};
    send(1,2,3,0,0,0); send(4,5,6,0,0,0); send(7,8,9,0,0,0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_midfill_valid got %0b want 0", out_valid); end
    send(10,11,12,0,0,0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %0b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
    checks++; if (out_cols !== 3'd4) begin errors++; $display("FAIL full_cols got %0d want 4", out_cols); end
    checks++; if (out_mtrx !== exp) begin errors++; $display("FAIL full_mtrx got %h want %h", out_mtrx, exp); end
    checks++; if (out_mtrx[DW-1:0] !== 21'h000400) begin errors++; $display("FAIL full_last_w got %h want 000400", out_mtrx[DW-1:0]); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL consume_hs got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    checks++; if (out_mtrx !== exp) begin errors++; $display("FAIL consume_hold got %h want %h", out_mtrx, exp); end
  endtask

  task automatic test_partial();
    logic [16*DW-1:0] exp;
    exp = {col(13,14,15,ONE), col(16,17,18,ONE), 84'd0, 84'd0};
    send(13,14,15,0,0,0); send(16,17,18,0,0,1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL partial_valid got %0b want 1", out_valid); end
    checks++; if (out_cols !== 3'd2) begin errors++; $display("FAIL partial_cols got %0d want 2", out_cols); end
    checks++; if (out_mtrx !== exp) begin errors++; $display("FAIL partial_mtrx got %h want %h", out_mtrx, exp); end
    consume();
  endtask

  task automatic test_wsel();
    logic [16*DW-1:0] exp;
    exp = {col(100,101,102,ONE), col(200,201,202,ONE), col(300,301,302,ONE), col(-5,7,9,-512)};
    send(100,101,102,0,0,0); send(200,201,202,0,0,0); send(300,301,302,0,0,0);
    send(-5,7,9,-512,1,0);
    checks++; if (out_cols !== 3'd4) begin errors++; $display("FAIL wsel_cols got %0d want 4", out_cols); end
    checks++; if (out_mtrx[4*DW-1 -: DW] !== 21'h1FFFFB) begin errors++; $display("FAIL wsel_x3 got %h want 1ffffb", out_mtrx[4*DW-1 -: DW]); end
    checks++; if (out_mtrx[DW-1:0] !== 21'h1FFE00) begin errors++; $display("FAIL wsel_w3 got %h want 1ffe00", out_mtrx[DW-1:0]); end
    checks++; if (out_mtrx !== exp) begin errors++; $display("FAIL wsel_mtrx got %h want %h", out_mtrx, exp); end
  endtask

  task automatic test_stall();
    logic [16*DW-1:0] held, exp;
    held = {col(100,101,102,ONE), col(200,201,202,ONE), col(300,301,302,ONE), col(-5,7,9,-512)};
    exp  = {col(20,21,22,ONE), col(23,24,25,ONE), col(26,27,28,ONE), col(29,30,31,ONE)};
    in_x = 21'sd20; in_y = 21'sd21; in_z = 21'sd22; in_wsel = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mtrx !== held) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got ready=%0b valid=%0b mtrx=%h want 0/1/%h", i, in_ready, out_valid, out_mtrx, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got ready=%0b valid=%0b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(23,24,25,0,0,0); send(26,27,28,0,0,0); send(29,30,31,0,0,0);
    checks++; if (out_mtrx !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL stall_pending got %h valid=%0b want %h", out_mtrx, out_valid, exp); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [16*DW-1:0] exp;
    send(1,1,1,0,0,0); send(2,2,2,0,0,0); send(3,3,3,0,0,0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cols !== 3'd0 || out_mtrx !== '0) begin
      errors++; $display("FAIL rstfill got valid=%0b ready=%0b cols=%0d mtrx=%h want 0/1/0/0", out_valid, in_ready, out_cols, out_mtrx); end
    exp = {col(41,42,43,ONE), col(44,45,46,ONE), col(47,48,49,ONE), col(50,51,52,ONE)};
    send(41,42,43,0,0,0); send(44,45,46,0,0,0); send(47,48,49,0,0,0); send(50,51,52,0,0,0);
    checks++; if (out_mtrx !== exp || out_cols !== 3'd4) begin errors++; $display("FAIL rstfill_batch got %h cols=%0d want %h cols=4", out_mtrx, out_cols, exp); end
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cols !== 3'd0 || out_mtrx !== '0) begin
      errors++; $display("FAIL rstfull got valid=%0b ready=%0b cols=%0d mtrx=%h want 0/1/0/0", out_valid, in_ready, out_cols, out_mtrx); end
    exp = {col(61,62,63,ONE), col(64,65,66,ONE), col(67,68,69,ONE), col(70,71,72,ONE)};
    send(61,62,63,0,0,0); send(64,65,66,0,0,0); send(67,68,69,0,0,0); send(70,71,72,0,0,0);
    checks++; if (out_mtrx !== exp || out_cols !== 3'd4) begin errors++; $display("FAIL rstfull_batch got %h cols=%0d want %h cols=4", out_mtrx, out_cols, exp); end
    consume();
  endtask

  task automatic test_nv1();
    for (int i = 0; i < 2; i++) begin
      a_x = DW'(5 + i); a_y = DW'(-6 - i); a_z = DW'(7 + i); a_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      checks++; if (a_ovalid !== 1'b1 || a_ready !== 1'b0 || a_cols !== 1'b1) begin
        errors++; $display("FAIL nv1_hs%0d got valid=%0b ready=%0b cols=%0d want 1/0/1", i, a_ovalid, a_ready, a_cols); end
      checks++; if (a_mtrx !== col(5 + i, -6 - i, 7 + i, ONE)) begin
        errors++; $display("FAIL nv1_mtrx%0d got %h want %h", i, a_mtrx, col(5 + i, -6 - i, 7 + i, ONE)); end
      a_oready = 1'b1; @(posedge clk); #1; a_oready = 1'b0;
      checks++; if (a_ready !== 1'b1 || a_ovalid !== 1'b0) begin
        errors++; $display("FAIL nv1_release%0d got ready=%0b valid=%0b want 1/0", i, a_ready, a_ovalid); end
    end
  endtask

  task automatic test_nv8();
    for (int i = 0; i < 8; i++) begin
      b_x = DW'(i*3 + 1); b_y = DW'(i*3 + 2); b_z = DW'(i*3 + 3); b_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 6) begin
        checks++; if (b_ovalid !== 1'b0) begin errors++; $display("FAIL nv8_early_valid got %0b want 0", b_ovalid); end
      end
    end
    b_valid = 1'b0;
    checks++; if (b_ovalid !== 1'b1 || b_cols !== 4'd8) begin errors++; $display("FAIL nv8_hs got valid=%0b cols=%0d want 1/8", b_ovalid, b_cols); end
    checks++; if (b_mtrx[32*DW-1 -: DW] !== 21'd1 || b_mtrx[DW-1:0] !== 21'h000400) begin
      errors++; $display("FAIL nv8_corners got top=%h bottom=%h want 000001/000400", b_mtrx[32*DW-1 -: DW], b_mtrx[DW-1:0]); end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (b_mtrx[4*DW*(8-j)-1 -: 4*DW] !== col(j*3 + 1, j*3 + 2, j*3 + 3, ONE)) begin
        errors++; $display("FAIL nv8_col%0d got %h want %h", j, b_mtrx[4*DW*(8-j)-1 -: 4*DW], col(j*3 + 1, j*3 + 2, j*3 + 3, ONE));
      end
    end
    b_oready = 1'b1; @(posedge clk); #1; b_oready = 1'b0;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL nv8_release got ready=%0b want 1", b_ready); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_wsel = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; in_w = '0;
    a_valid = 1'b0; a_oready = 1'b0; a_x = '0; a_y = '0; a_z = '0;
    b_valid = 1'b0; b_oready = 1'b0; b_x = '0; b_y = '0; b_z = '0;
    test_reset();
    test_full_batch();
    test_partial();
    test_wsel();
    test_stall();
    test_reset_mid();
    test_nv1();
    test_nv8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
